// File: rtl/sdram_resp_pkg.sv
// Shared constants for the SDRAM responder: word width, legal parameter ranges,
// and the stall-injector LFSR seed/taps with its step function.
package sdram_resp_pkg;

    localparam int WORD_W   = 32;
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 8;
    localparam int PEND_MIN = 1;
    localparam int PEND_W   = $clog2(LAT_MAX + 1);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// Avalon-MM pipelined-read bus between the accelerator master and the SDRAM responder.
interface sdram_responder_if;
    import sdram_resp_pkg::*;

    logic              slave_waitrequest;
    logic [31:0]       slave_address;
    logic              slave_read;
    logic [WORD_W-1:0] slave_readdata;
    logic              slave_readdatavalid;
    logic              slave_write;
    logic [WORD_W-1:0] slave_writedata;

    modport master (
        input  slave_waitrequest, slave_readdata, slave_readdatavalid,
        output slave_address, slave_read, slave_write, slave_writedata
    );

    modport slave (
        output slave_waitrequest, slave_readdata, slave_readdatavalid,
        input  slave_address, slave_read, slave_write, slave_writedata
    );

endinterface

// File: rtl/read_delay_pipe.sv
// Fixed-latency return pipeline of {valid, data}; a stage's data only moves with a
// valid beat, so the last stage keeps the most recently returned word.
module read_delay_pipe
    import sdram_resp_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    logic [DEPTH-1:0]  vld_r;
    logic [WORD_W-1:0] dat_r [DEPTH];

    // Shift valid every cycle; advance data only behind a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            vld_r[0] <= in_valid;
            if (in_valid) begin
                dat_r[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/sdram_responder.sv
// On-chip SDRAM stand-in: word array behind an Avalon-MM pipelined-read slave.
// Define SDRAM_RESP_STALL_EN to enable the LFSR-driven waitrequest stall injector.
module sdram_responder
    import sdram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic                clk,
    input  logic                rst,
    sdram_responder_if.slave    bus,
    output logic                proto_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PEND_W-1:0] MAXP = PEND_W'(MAX_PENDING);

    logic [WORD_W-1:0]     mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_s;
    logic [PEND_W-1:0]     pending_r;
    logic [PEND_W-1:0]     avail_s;
    logic                  conflict_s;
    logic                  stall_s;
    logic                  wait_s;
    logic                  acc_rd_s;
    logic                  acc_wr_s;
    logic                  ret_s;
    logic                  proto_err_r;
    logic                  unused_s;

    assign idx_s      = bus.slave_address[ADDR_WIDTH+1:2];
    assign unused_s   = ^{bus.slave_address[31:ADDR_WIDTH+2], bus.slave_address[1:0]};
    assign conflict_s = bus.slave_read & bus.slave_write;
    assign avail_s    = pending_r - {{(PEND_W-1){1'b0}}, ret_s};

`ifdef SDRAM_RESP_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall LFSR; a stall is flagged one cycle in four on average.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // Waitrequest: a slot freed by this cycle's return may be reused immediately.
    always_comb begin
        wait_s = 1'b0;
        if (rst) begin
            wait_s = 1'b1;
        end else if (conflict_s) begin
            wait_s = 1'b1;
        end else if (bus.slave_read && (avail_s == MAXP)) begin
            wait_s = 1'b1;
        end else if (stall_s) begin
            wait_s = 1'b1;
        end else begin
            wait_s = 1'b0;
        end
    end

    assign acc_rd_s              = bus.slave_read  & ~wait_s;
    assign acc_wr_s              = bus.slave_write & ~wait_s;
    assign bus.slave_waitrequest = wait_s;

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (acc_wr_s) begin
            mem_r[idx_s] <= bus.slave_writedata;
        end
    end

    // Outstanding-read counter and sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= {PEND_W{1'b0}};
            proto_err_r <= 1'b0;
        end else begin
            case ({acc_rd_s, ret_s})
                2'b10:   pending_r <= pending_r + {{(PEND_W-1){1'b0}}, 1'b1};
                2'b01:   pending_r <= pending_r - {{(PEND_W-1){1'b0}}, 1'b1};
                default: pending_r <= pending_r;
            endcase
            if (conflict_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_r;

    read_delay_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc_rd_s),
        .in_data   (mem_r[idx_s]),
        .out_valid (ret_s),
        .out_data  (bus.slave_readdata)
    );

    assign bus.slave_readdatavalid = ret_s;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed and scoreboard bench for sdram_responder (ADDR_WIDTH=10, READ_LATENCY=3,
// MAX_PENDING=2); models the stall LFSR when SDRAM_RESP_STALL_EN is defined.
module tb_sdram_responder;

    localparam int LAT  = 3;
    localparam int MAXP = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    sdram_responder_if bus();

    sdram_responder #(
        .ADDR_WIDTH   (10),
        .READ_LATENCY (LAT),
        .MAX_PENDING  (MAXP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    logic [31:0] mem_m [int];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          busy_cnt = 0;
    logic [31:0] last_data = 32'h0;
    logic        exp_perr = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle: check returns from the previous edge, drive, check waitrequest, update model.
    task automatic step(input logic r_v, input logic w_v, input logic [31:0] addr,
                        input logic [31:0] wd, input logic use_hand, input logic [31:0] hand,
                        input logic rs, output logic acc);
        logic        stall_m;
        logic        exp_wait;
        int          size_before;
        int          idx;
        logic [31:0] rdat;
        @(negedge clk);
        cyc++;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            check_eq("readdatavalid", bus.slave_readdatavalid, 1'b1);
            check_eq("readdata", bus.slave_readdata, expq[0].data);
            last_data = expq[0].data;
            void'(expq.pop_front());
        end else begin
            check_eq("readdatavalid_idle", bus.slave_readdatavalid, 1'b0);
            check_eq("readdata_hold", bus.slave_readdata, last_data);
        end
        check_eq("proto_err", proto_err, exp_perr);

        rst                 = rs;
        bus.slave_read      = r_v;
        bus.slave_write     = w_v;
        bus.slave_address   = addr;
        bus.slave_writedata = wd;
        #1;
        stall_m = 1'b0;
`ifdef SDRAM_RESP_STALL_EN
        stall_m = (lfsr_m[1:0] == 2'b00);
`endif
        size_before = expq.size();
        exp_wait = rs | (r_v & w_v) | (r_v && size_before == MAXP) | stall_m;
        check_eq("waitrequest", bus.slave_waitrequest, exp_wait);
        acc = (r_v | w_v) & ~exp_wait;

        if (!rs) begin
            busy_cnt++;
            if (bus.slave_waitrequest && !(r_v & w_v) && !(r_v && size_before == MAXP))
                stall_cnt++;
        end
        idx = int'(addr[11:2]);
        if (acc && w_v) mem_m[idx] = wd;
        if (acc && r_v) begin
            if (use_hand) rdat = hand;
            else if (mem_m.exists(idx)) rdat = mem_m[idx];
            else rdat = 32'hxxxx_xxxx;
            expq.push_back('{cyc + LAT, rdat});
        end
        if (rs) exp_perr = 1'b0;
        else if (r_v & w_v) exp_perr = 1'b1;
        if (rs) lfsr_m = 16'hACE1;
        else lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        if (rs) begin
            expq.delete();
            last_data = 32'h0;
        end
    endtask

    // Hold a request until accepted, with a bounded retry budget.
    task automatic issue(input logic r_v, input logic w_v, input logic [31:0] addr,
                         input logic [31:0] wd, input logic use_hand, input logic [31:0] hand);
        logic acc;
        int   n;
        n = 0;
        do begin
            step(r_v, w_v, addr, wd, use_hand, hand, 1'b0, acc);
            n++;
        end while (!acc && n < 30);
        check_eq("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, acc);
    endtask

    initial begin
        logic        acc;
        logic [31:0] r;
        logic [31:0] addr;
        logic [3:0]  ix;
        int          op;
        rst                 = 1'b1;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_address   = 32'h0;
        bus.slave_writedata = 32'h0;
        repeat (2) @(negedge clk);
        do_reset();
        do_reset();

        // Write then read next cycle: data three cycles after acceptance.
        issue(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
        idle(5);

        // Address aliasing: upper bits and byte offset ignored.
        issue(1'b0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_1004, 32'h0, 1'b1, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 32'h0000_0007, 32'h0, 1'b1, 32'hA5A5_A5A5);
        idle(5);

        // Six back-to-back reads throttled by the two-deep pending limit.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
            else            issue(1'b1, 1'b0, 32'hFFFF_F004, 32'h0, 1'b1, 32'hA5A5_A5A5);
        end
        idle(5);

        // Read+write conflict: nothing accepted, array unchanged, sticky error.
        step(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, acc);
        idle(2);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
        idle(5);

        // Reset with reads in flight: returns discarded, array kept, error cleared.
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
        issue(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
        do_reset();
        idle(6);
        issue(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'h0000_0000 | 32'hxxxx_xxxx);
        idle(5);

        // Scoreboard phase over 16 aliased words.
        stall_cnt = 0;
        busy_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            r  = $urandom();
            ix = 4'(i);
            issue(1'b0, 1'b1, {r[31:12], 6'b0, ix, 2'b0}, $urandom(), 1'b0, 32'h0);
        end
        for (int i = 0; i < 400; i++) begin
            r    = $urandom();
            ix   = 4'($urandom_range(0, 15));
            addr = {r[31:12], 6'b0, ix, r[1:0]};
            op   = $urandom_range(0, 3);
            case (op)
                1, 2:    step(1'b1, 1'b0, addr, 32'h0, 1'b0, 32'h0, 1'b0, acc);
                3:       step(1'b0, 1'b1, addr, $urandom(), 1'b0, 32'h0, 1'b0, acc);
                default: step(1'b0, 1'b0, addr, 32'h0, 1'b0, 32'h0, 1'b0, acc);
            endcase
        end
        idle(6);
        check_eq("all_returned", expq.size(), 32'd0);
`ifdef SDRAM_RESP_STALL_EN
        check_eq("stall_share", (stall_cnt * 100 >= busy_cnt * 15) && (stall_cnt * 100 <= busy_cnt * 35), 1'b1);
`else
        check_eq("stall_cycles", stall_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
